pulse_frame_arbiter: RTL

Round-robin arbiter and sequencer that shares one button-code pulse engine (3-bit code input `b[3:1]`, single pulse output) among `N_REQ` requesters. It grants one requester at a time and drives the engine's code input for exactly one engine frame. A frame is 4 cycles for codes 001/101 and 8 cycles for 010/110. When the frame ends, the block acknowledges the requester. It sits between the requester ports and the engine; the engine is reset by the same `rst`.

---
 rtl/pulse_pkg.sv | 24 ++
 rtl/rr_pick.sv | 39 +++
 rtl/pulse_frame_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse engine front-end: button codes, frame lengths,
// arbiter state encoding and code classification helpers.
package pulse_pkg;

    localparam logic [2:0] CODE_B1   = 3'b001;
    localparam logic [2:0] CODE_B3B1 = 3'b101;
    localparam logic [2:0] CODE_B2   = 3'b010;
    localparam logic [2:0] CODE_B3B2 = 3'b110;

    localparam int unsigned FRAME_SHORT = 4;
    localparam int unsigned FRAME_LONG  = 8;

    typedef enum logic {StIdle, StRun} state_e;

    function automatic logic code_valid(input logic [2:0] c);
        return (c == CODE_B1) || (c == CODE_B3B1) || (c == CODE_B2) || (c == CODE_B3B2);
    endfunction

    // Last count value of a frame; bit1 of a valid code selects the long frame.
    function automatic logic [2:0] frame_last(input logic is_long);
        return is_long ? 3'(FRAME_LONG - 1) : 3'(FRAME_SHORT - 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first asserted request at or after the pointer,
// wrapping modulo N_REQ.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PW-1:0]    idx_o,
    output logic             any_o
);

    localparam logic [PW:0] NumReq = (PW + 1)'(N_REQ);

    logic [PW:0]   sum;
    logic [PW-1:0] pos;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        sum   = '0;
        pos   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr_i} + (PW + 1)'(k);
            if (sum >= NumReq) begin
                sum = sum - NumReq;
            end
            pos = sum[PW-1:0];
            if (!any_o && req_i[pos]) begin
                any_o      = 1'b1;
                idx_o      = pos;
                gnt_o[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pulse_frame_arbiter.sv
// Round-robin arbiter that lends the shared pulse engine's code input to one requester
// for exactly one engine frame, then acknowledges it.
module pulse_frame_arbiter
    import pulse_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [3*N_REQ-1:0] code,
    output logic [2:0]         b_out,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   ack,
    output logic               err,
    output logic               busy,
    output logic               frame_long
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [2:0]       b_out_q, b_out_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             err_q, err_d;
    logic             frame_long_q, frame_long_d;

    logic [N_REQ-1:0] win_oh;
    logic [PW-1:0]    win_idx;
    logic             win_any;
    logic [2:0]       win_code;
    logic [PW-1:0]    ptr_next;
    logic [2:0]       last;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (win_oh),
        .idx_o (win_idx),
        .any_o (win_any)
    );

    always_comb begin
        win_code = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win_oh[i]) begin
                win_code = code[3*i +: 3];
            end
        end
    end

    assign ptr_next = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
    assign last     = frame_last(frame_long_q);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        b_out_d      = b_out_q;
        grant_d      = grant_q;
        frame_long_d = frame_long_q;
        ack_d        = '0;
        err_d        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (win_any) begin
                    ptr_d = ptr_next;
                    if (code_valid(win_code)) begin
                        state_d      = StRun;
                        b_out_d      = win_code;
                        grant_d      = win_oh;
                        frame_long_d = win_code[1];
                        cnt_d        = '0;
                    end else begin
                        ack_d = win_oh;
                        err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                cnt_d = cnt_q + 3'd1;
                // ack is registered, so raise it one count early to land on the last count
                if (cnt_q == last - 3'd1) begin
                    ack_d = grant_q;
                end
                if (cnt_q == last) begin
                    state_d      = StIdle;
                    cnt_d        = '0;
                    b_out_d      = '0;
                    grant_d      = '0;
                    frame_long_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            cnt_q        <= '0;
            b_out_q      <= '0;
            grant_q      <= '0;
            ack_q        <= '0;
            err_q        <= 1'b0;
            frame_long_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            b_out_q      <= b_out_d;
            grant_q      <= grant_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            frame_long_q <= frame_long_d;
        end
    end

    assign b_out      = b_out_q;
    assign grant      = grant_q;
    assign ack        = ack_q;
    assign err        = err_q;
    assign busy       = (state_q == StRun);
    assign frame_long = frame_long_q;

endmodule
